// File: rtl/fifo_sdram_writer_if.sv
// Bundles the FIFO read port, SDRAM write port and status of fifo_sdram_writer.
// master = the writer; slave = FIFO, SDRAM controller and frame control around it.
interface fifo_sdram_writer_if;
  logic        frame_start;
  logic        fifo_rdempty;
  logic [15:0] fifo_q;
  logic        fifo_rdreq;
  logic        dram_req;
  logic        dram_we_n;
  logic [23:0] dram_addr;
  logic [15:0] dram_wdata;
  logic        dram_ack;
  logic        busy;
  logic        frame_done;
  logic        disp_buf;
  logic [7:0]  drop_cnt;

  modport master (
    input  frame_start, fifo_rdempty, fifo_q, dram_ack,
    output fifo_rdreq, dram_req, dram_we_n, dram_addr, dram_wdata,
           busy, frame_done, disp_buf, drop_cnt
  );

  modport slave (
    output frame_start, fifo_rdempty, fifo_q, dram_ack,
    input  fifo_rdreq, dram_req, dram_we_n, dram_addr, dram_wdata,
           busy, frame_done, disp_buf, drop_cnt
  );
endinterface

// File: rtl/fifo_sdram_writer.sv
// Moves one field of FIFO words to SDRAM, one write at a time; fifo_rdreq -> dram_req is 2 cycles.
// A request is held until dram_ack; DOUBLE_BUFFER_EN alternates between two frame buffers.
module fifo_sdram_writer #(
  parameter int unsigned FRAME_WORDS = 172800,
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter logic [23:0] BUF_STRIDE  = 24'h040000
) (
  input logic                 clk,
  input logic                 reset_n,
  fifo_sdram_writer_if.master bus
);

  typedef enum logic [2:0] {IDLE, WAIT_DATA, FETCH, LATCH, WRITE} state_t;

  localparam logic [17:0] LAST_WORD = 18'(FRAME_WORDS - 1);

  state_t      state_q, state_d;
  logic [17:0] word_cnt_q, word_cnt_d;
  logic [7:0]  drop_q, drop_d, drop_inc;
  logic        req_q, req_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        abort_pend_q, abort_pend_d;
  logic        frame_done_q, frame_done_d;
  logic        rdreq;
  logic        accept;
  logic        last_word;
  logic        wr_buf;
  logic [23:0] buf_base;

  assign buf_base  = BASE_ADDR + (wr_buf ? BUF_STRIDE : 24'h000000);
  assign accept    = req_q & bus.dram_ack;
  assign last_word = (word_cnt_q == LAST_WORD);
  assign drop_inc  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      drop_q       <= '0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      abort_pend_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      drop_q       <= drop_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      abort_pend_q <= abort_pend_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    drop_d       = drop_q;
    req_d        = req_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    abort_pend_d = abort_pend_q;
    frame_done_d = 1'b0;
    rdreq        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          state_d    = WAIT_DATA;
          word_cnt_d = '0;
        end
      end
      WAIT_DATA: begin
        if (bus.frame_start) begin
          drop_d     = drop_inc;
          word_cnt_d = '0;
        end else if (!bus.fifo_rdempty) begin
          rdreq   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // An abort here discards the word already popped from the FIFO.
        if (bus.frame_start) begin
          drop_d     = drop_inc;
          word_cnt_d = '0;
          state_d    = WAIT_DATA;
        end else begin
          wdata_d = bus.fifo_q;
          addr_d  = buf_base + {6'd0, word_cnt_q};
          req_d   = 1'b1;
          state_d = LATCH;
        end
      end
      LATCH, WRITE: begin
        if (accept) begin
          req_d        = 1'b0;
          abort_pend_d = 1'b0;
          // A new field arriving with the final ack still completes this one.
          if (abort_pend_q || (bus.frame_start && !last_word)) begin
            drop_d     = drop_inc;
            word_cnt_d = '0;
            state_d    = WAIT_DATA;
          end else if (last_word) begin
            frame_done_d = 1'b1;
            word_cnt_d   = '0;
            state_d      = bus.frame_start ? WAIT_DATA : IDLE;
          end else begin
            word_cnt_d = word_cnt_q + 18'd1;
            state_d    = WAIT_DATA;
          end
        end else begin
          state_d = WRITE;
          if (bus.frame_start) abort_pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DOUBLE_BUFFER_EN
  logic wr_buf_q;
  logic disp_buf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_buf_q   <= 1'b0;
      disp_buf_q <= 1'b0;
    end else if (frame_done_d) begin
      disp_buf_q <= wr_buf_q;
      wr_buf_q   <= ~wr_buf_q;
    end
  end

  assign wr_buf       = wr_buf_q;
  assign bus.disp_buf = disp_buf_q;
`else
  assign wr_buf       = 1'b0;
  assign bus.disp_buf = 1'b0;
`endif

  assign bus.fifo_rdreq = rdreq;
  assign bus.dram_req   = req_q;
  assign bus.dram_we_n  = ~req_q;
  assign bus.dram_addr  = addr_q;
  assign bus.dram_wdata = wdata_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = frame_done_q;
  assign bus.drop_cnt   = drop_q;

endmodule
